// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: fetch FSM encoding and immediate/word-size constants shared with decode.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {ST_RST, ST_ISSUE, ST_WAIT, ST_HOLD} fetch_state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam int IMM_W      = 16;
    localparam int WORD_SHIFT = 2;
    localparam int SEXT_W     = 32 - IMM_W - WORD_SHIFT;
    localparam int JUMP_W     = 26;

    function automatic logic [31-WORD_SHIFT:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{SEXT_W{imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: instruction-memory request handshake between fetch and imem.
interface fetch_pc_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;

    modport master(output imem_req_valid, imem_addr, input imem_req_ready);
    modport slave(input imem_req_valid, imem_addr, output imem_req_ready);
endinterface

// File: rtl/fetch_pc_unit_pc_redirect_calc.sv
// pc_redirect_calc: branch/jump target arithmetic and jump-over-branch redirect selection.
module pc_redirect_calc
    import fetch_pc_unit_pkg::*;
(
    input  logic [3:0]        pc_region,
    input  logic              branch_taken,
    input  logic [31:0]       branch_base,
    input  logic [IMM_W-1:0]  branch_imm,
    input  logic              jump_valid,
    input  logic [JUMP_W-1:0] jump_target,
    output logic              redir_valid,
    output logic [31:0]       redir_pc
);
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;

    assign branch_tgt  = branch_base + {sext_imm(branch_imm), {WORD_SHIFT{1'b0}}};
    assign jump_tgt    = {pc_region, jump_target, {WORD_SHIFT{1'b0}}};
    assign redir_valid = jump_valid | branch_taken;
    assign redir_pc    = jump_valid ? jump_tgt : branch_tgt;
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register and fetch FSM issuing word-aligned imem requests with redirect handling.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_base,
    input  logic [IMM_W-1:0]  branch_imm,
    input  logic              jump_valid,
    input  logic [JUMP_W-1:0] jump_target,
    fetch_pc_unit_if.master   imem,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc_plus4
);
    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pend_pc;
    logic         pend_valid;
    logic         redir_valid;
    logic [31:0]  redir_pc;
    logic         busy;
    logic         hs;

    pc_redirect_calc u_calc (
        .pc_region   (pc[31:28]),
        .branch_taken(branch_taken),
        .branch_base (branch_base),
        .branch_imm  (branch_imm),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc)
    );

    assign busy                = state == ST_ISSUE || state == ST_WAIT;
    assign hs                  = busy && imem.imem_req_ready;
    assign imem.imem_req_valid = busy;
    assign imem.imem_addr      = pc;

    // A stalled handshake is dropped and refetched later, so it is squashed like a redirect.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_RST;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_pc_plus4 <= '0;
        end else begin
            if_valid <= 1'b0;
            case (state)
                ST_RST: state <= ST_ISSUE;
                ST_ISSUE, ST_WAIT: begin
                    if (hs) begin
                        if_valid    <= !(redir_valid || pend_valid || stall);
                        if_pc       <= pc;
                        if_pc_plus4 <= pc + WORD_BYTES;
                        pc          <= redir_valid ? redir_pc : pend_valid ? pend_pc : stall ? pc : pc + WORD_BYTES;
                        pend_valid  <= 1'b0;
                        state       <= stall ? ST_HOLD : ST_ISSUE;
                    end else begin
                        if (redir_valid) begin
                            pend_valid <= 1'b1;
                            pend_pc    <= redir_pc;
                        end
                        state <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (redir_valid) pc <= redir_pc;
                    state <= stall ? ST_HOLD : ST_ISSUE;
                end
                default: state <= ST_RST;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed and randomized fetch traffic checked against a transaction-level PC model.
module tb_fetch_pc_unit;
    localparam logic [31:0] RP = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_base = '0;
    logic [15:0] branch_imm = '0;
    logic        jump_valid = 1'b0;
    logic [25:0] jump_target = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    fetch_pc_unit_if imem();

    fetch_pc_unit #(.RESET_PC(RP)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .stall       (stall),
        .branch_taken(branch_taken),
        .branch_base (branch_base),
        .branch_imm  (branch_imm),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .imem        (imem),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a requested address, an optional pending redirect, one fetch record.
    logic [31:0] m_pc = RP;
    logic        m_req = 1'b0;
    logic        m_boot = 1'b1;
    logic        m_ifv = 1'b0;
    logic [31:0] m_ifpc = '0;
    logic [31:0] pend[$];

    initial begin
        logic        red;
        logic [31:0] tgt;
        forever begin
            @(posedge clock or negedge resetn);
            if (!resetn) begin
                m_pc = RP; m_req = 1'b0; m_boot = 1'b1; m_ifv = 1'b0; m_ifpc = '0;
                pend.delete();
            end else begin
                red = jump_valid || branch_taken;
                tgt = jump_valid ? ((m_pc & 32'hF000_0000) | (32'(jump_target) * 32'd4))
                                 : branch_base + 32'(int'($signed(branch_imm)) * 4);
                m_ifv = 1'b0;
                if (m_boot) begin
                    m_boot = 1'b0;
                    m_req = 1'b1;
                end else if (m_req) begin
                    if (imem.imem_req_ready) begin
                        m_ifv = !(red || pend.size() != 0 || stall);
                        m_ifpc = m_pc;
                        if (red) m_pc = tgt;
                        else if (pend.size() != 0) m_pc = pend[0];
                        else if (!stall) m_pc = m_pc + 32'd4;
                        pend.delete();
                        m_req = !stall;
                    end else if (red) begin
                        pend.delete();
                        pend.push_back(tgt);
                    end
                end else begin
                    if (red) m_pc = tgt;
                    m_req = !stall;
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("req_valid", {31'b0, imem.imem_req_valid}, {31'b0, m_req});
        if (m_req || !resetn) chk("imem_addr", imem.imem_addr, m_pc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_ifv});
        if (m_ifv || !resetn) begin
            chk("if_pc", if_pc, m_ifpc);
            chk("if_pc_plus4", if_pc_plus4, m_ifv ? m_ifpc + 32'd4 : 32'd0);
        end
    end

    task automatic cyc(input logic rdy, input logic stl, input logic br, input logic [31:0] base,
                       input logic [15:0] imm, input logic jv, input logic [25:0] jt);
        imem.imem_req_ready = rdy;
        stall = stl;
        branch_taken = br;
        branch_base = base;
        branch_imm = imm;
        jump_valid = jv;
        jump_target = jt;
        @(negedge clock);
    endtask

    initial begin
        imem.imem_req_ready = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_addr0", imem.imem_addr, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_addr4", imem.imem_addr, 32'h4);
        chk("lit_ifpc0", if_pc, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_addr12", imem.imem_addr, 32'hC);
        chk("lit_ifpc8", if_pc, 32'h8);
        cyc(1, 0, 1, 32'h20, 16'hFFFC, 0, 0);
        chk("lit_branch_addr", imem.imem_addr, 32'h10);
        chk("lit_branch_squash", {31'b0, if_valid}, 32'h0);
        chk("lit_model_branch", m_pc, 32'h10);
        cyc(1, 0, 0, 0, 0, 1, 26'h2);
        chk("lit_jump8", imem.imem_addr, 32'h8);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 26'h40);
        chk("lit_wait_hold", imem.imem_addr, 32'h8);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("lit_wait_hold2", imem.imem_addr, 32'h8);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_wait_squash", {31'b0, if_valid}, 32'h0);
        chk("lit_pend_addr", imem.imem_addr, 32'h100);
        cyc(1, 0, 1, 32'h1000, 16'h1, 1, 26'h80);
        chk("lit_jump_wins", imem.imem_addr, 32'h200);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("lit_stall_novalid", {31'b0, imem.imem_req_valid}, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_stall_resume", imem.imem_addr, 32'h200);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'h40, 16'h4, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_stall_redirect", imem.imem_addr, 32'h50);
        cyc(1, 0, 1, 32'h0, 16'hFFFF, 0, 0);
        chk("lit_wrap_pc", imem.imem_addr, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_wrap_zero", imem.imem_addr, 32'h0);
        chk("lit_wrap_plus4", if_pc_plus4, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        #2 resetn = 1'b0;
        #1 chk("lit_async_drop", {31'b0, imem.imem_req_valid}, 32'h0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_restart", imem.imem_addr, RP);
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                $urandom(), 16'($urandom()), $urandom_range(0, 13) == 0, 26'($urandom()));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
